// File: rtl/tilemap_write_scheduler_pkg.sv
// Shared types and constants for the tile-map write scheduler.
package tilemap_write_scheduler_pkg;

  localparam int TILE_ADDR_W        = 5;
  localparam int TILE_DATA_W        = 8;
  localparam int LINE_W             = 9;
  localparam int DEFAULT_V_ACTIVE   = 272;
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_TILE_COUNT = 32;
  localparam int ENTRY_W            = TILE_ADDR_W + TILE_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] address;
    logic [TILE_DATA_W-1:0] data;
  } tile_write_t;

  // Builds a buffered write entry from a requester's address and tile code.
  function automatic tile_write_t packWrite(input logic [TILE_ADDR_W-1:0] address,
                                            input logic [TILE_DATA_W-1:0] data);
    tile_write_t entry;
    entry.address = address;
    entry.data    = data;
    return entry;
  endfunction

endpackage

// File: rtl/tilemap_write_scheduler_fifo.sv
// Show-ahead synchronous FIFO buffering tile writes until vertical blank.
module tile_write_fifo
  import tilemap_write_scheduler_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_data   = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tilemap_write_scheduler.sv
// Buffers tile writes from two requesters and commits them to the tile RAM
// only during vertical blank, with an optional whole-map clear first.
module tilemap_write_scheduler
  import tilemap_write_scheduler_pkg::*;
#(
  parameter int         FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int         V_ACTIVE   = DEFAULT_V_ACTIVE,
  parameter int         TILE_COUNT = DEFAULT_TILE_COUNT,
  parameter logic [7:0] CLEAR_TILE = 8'h00
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LINE_W-1:0]      i_y,
  input  logic                   i_req0_valid,
  input  logic [TILE_ADDR_W-1:0] i_req0_address,
  input  logic [TILE_DATA_W-1:0] i_req0_data,
  output logic                   o_req0_ready,
  input  logic                   i_req1_valid,
  input  logic [TILE_ADDR_W-1:0] i_req1_address,
  input  logic [TILE_DATA_W-1:0] i_req1_data,
  output logic                   o_req1_ready,
  input  logic                   i_clear,
  output logic [TILE_ADDR_W-1:0] o_ram_address,
  output logic [TILE_DATA_W-1:0] o_ram_data,
  output logic                   o_ram_wren,
  output logic                   o_frame_tick,
  output logic                   o_busy
);

  localparam logic [LINE_W-1:0]      BLANK_LINE      = LINE_W'(V_ACTIVE);
  localparam logic [TILE_ADDR_W-1:0] LAST_CLEAR_ADDR = TILE_ADDR_W'(TILE_COUNT - 1);
  localparam int                     CW              = $clog2(FIFO_DEPTH) + 1;

  sched_state_t           r_state;
  logic [TILE_ADDR_W-1:0] r_clearAddr;
  logic                   r_clearPending;
  logic                   r_lastGrant;
  logic                   r_blankQ;
  logic                   r_frameTick;
  logic [TILE_ADDR_W-1:0] r_ramAddress;
  logic [TILE_DATA_W-1:0] r_ramData;
  logic                   r_ramWren;

  logic                   w_blank;
  logic                   w_bothValid;
  logic                   w_ready0;
  logic                   w_ready1;
  logic                   w_push0;
  logic                   w_push1;
  logic                   w_push;
  tile_write_t            w_pushEntry;
  tile_write_t            w_headEntry;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;

  assign w_blank = (i_y >= BLANK_LINE);

  // A requester loses only when both want the slot and it was served last.
  assign w_bothValid = i_req0_valid & i_req1_valid;
  assign w_ready0    = ~i_rst & ~w_full & ~(w_bothValid & ~r_lastGrant);
  assign w_ready1    = ~i_rst & ~w_full & ~(w_bothValid & r_lastGrant);
  assign w_push0     = i_req0_valid & w_ready0;
  assign w_push1     = i_req1_valid & w_ready1;
  assign w_push      = w_push0 | w_push1;
  assign w_pushEntry = w_push1 ? packWrite(i_req1_address, i_req1_data)
                               : packWrite(i_req0_address, i_req0_data);

  assign w_pop = (r_state == ST_DRAIN) & w_blank & ~w_empty;

  tile_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(tile_write_t))
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_pushEntry),
    .i_pop   (w_pop),
    .o_data  (w_headEntry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Remember who was served so the other requester wins the next tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lastGrant <= 1'b1;
    end else if (w_push0) begin
      r_lastGrant <= 1'b0;
    end else if (w_push1) begin
      r_lastGrant <= 1'b1;
    end
  end

  // Rising edge of blank gives one game-timing tick per frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blankQ    <= 1'b0;
      r_frameTick <= 1'b0;
    end else begin
      r_blankQ    <= w_blank;
      r_frameTick <= w_blank & ~r_blankQ;
    end
  end

  // Commit sequencer: clear first, then drain, and only ever while blanking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_clearAddr    <= '0;
      r_clearPending <= 1'b0;
      r_ramAddress   <= '0;
      r_ramData      <= '0;
      r_ramWren      <= 1'b0;
    end else begin
      r_ramWren <= 1'b0;
      if (i_clear && (r_state != ST_CLEAR)) begin
        r_clearPending <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_blank && r_clearPending) begin
            r_state        <= ST_CLEAR;
            r_clearAddr    <= '0;
            r_clearPending <= 1'b0;
          end else if (w_blank && !w_empty) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_CLEAR: begin
          if (w_blank) begin
            r_ramWren    <= 1'b1;
            r_ramAddress <= r_clearAddr;
            r_ramData    <= CLEAR_TILE;
            if (r_clearAddr == LAST_CLEAR_ADDR) begin
              r_state <= w_empty ? ST_IDLE : ST_DRAIN;
            end else begin
              r_clearAddr <= r_clearAddr + TILE_ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_ramWren    <= 1'b1;
            r_ramAddress <= w_headEntry.address;
            r_ramData    <= w_headEntry.data;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req0_ready  = w_ready0;
  assign o_req1_ready  = w_ready1;
  assign o_ram_address = r_ramAddress;
  assign o_ram_data    = r_ramData;
  assign o_ram_wren    = r_ramWren;
  assign o_frame_tick  = r_frameTick;
  assign o_busy        = (w_count != '0) | r_clearPending | (r_state == ST_CLEAR);

endmodule

// File: tb/tb_tilemap_write_scheduler.sv
// Directed testbench for the tile-map write scheduler.
module tb_tilemap_write_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] y;
  logic       v0, v1, clr;
  logic [4:0] a0, a1;
  logic [7:0] d0, d1;
  logic       r0, r1;
  logic [4:0] ramAddr;
  logic [7:0] ramData;
  logic       ramWren, frameTick, busy;

  int compared   = 0;
  int mismatched = 0;
  int tickCount  = 0;
  logic [12:0] wrQ[$];
  logic [12:0] expQ[$];

  tilemap_write_scheduler dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_y            (y),
    .i_req0_valid   (v0),
    .i_req0_address (a0),
    .i_req0_data    (d0),
    .o_req0_ready   (r0),
    .i_req1_valid   (v1),
    .i_req1_address (a1),
    .i_req1_data    (d1),
    .o_req1_ready   (r1),
    .i_clear        (clr),
    .o_ram_address  (ramAddr),
    .o_ram_data     (ramData),
    .o_ram_wren     (ramWren),
    .o_frame_tick   (frameTick),
    .o_busy         (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Capture every RAM write and frame tick on the quiet clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ramWren) wrQ.push_back({ramAddr, ramData});
      if (frameTick) tickCount = tickCount + 1;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushReq0(input logic [4:0] addr, input logic [7:0] data);
    v0 = 1'b1; a0 = addr; d0 = data;
    nextCycle();
    v0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; y = 9'd0; v0 = 0; v1 = 0; clr = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    #3;
    compared++; if (ramWren !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wren: got %b want 0", ramWren); end
    compared++; if (frameTick !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tick: got %b want 0", frameTick); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++; if (ramAddr !== 5'd0 || ramData !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_ram_bus: got %0d/%h want 0/00", ramAddr, ramData); end
    compared++; if (r0 !== 1'b0 || r1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready_low: got %b%b want 00", r0, r1); end
    nextCycle(); nextCycle();
    rst = 1'b0;
    #1;
    compared++; if (r0 !== 1'b1 || r1 !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ready: got %b%b want 11", r0, r1); end
  endtask

  task automatic test_reset_mid_drain();
    y = 9'd100;
    pushReq0(5'd1, 8'h31);
    pushReq0(5'd2, 8'h32);
    pushReq0(5'd3, 8'h33);
    y = 9'd272;
    nextCycle(); nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd1) begin mismatched++; $display("[TB] FAIL middrain_active: got wren %b addr %0d want 1/1", ramWren, ramAddr); end
    rst = 1'b1;
    #1;
    compared++; if (ramWren !== 1'b0) begin mismatched++; $display("[TB] FAIL middrain_wren_reset: got %b want 0", ramWren); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL middrain_fifo_empty: busy got %b want 0", busy); end
    y = 9'd0;
    nextCycle();
    rst = 1'b0;
    v0 = 1'b1; a0 = 5'd0; d0 = 8'd0;
    #1;
    compared++; if (r0 !== 1'b1) begin mismatched++; $display("[TB] FAIL middrain_ready0: got %b want 1", r0); end
    v0 = 1'b0;
    nextCycle();
  endtask

  task automatic test_basic_drain();
    y = 9'd100;
    wrQ.delete();
    pushReq0(5'd3, 8'h11);
    pushReq0(5'd4, 8'h22);
    repeat (3) nextCycle();
    compared++; if (ramWren !== 1'b0 || wrQ.size() != 0) begin mismatched++; $display("[TB] FAIL drain_hold_active: got wren %b writes %0d want 0/0", ramWren, wrQ.size()); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_busy_queued: got %b want 1", busy); end
    tickCount = 0;
    y = 9'd272;
    nextCycle();
    compared++; if (frameTick !== 1'b1 || ramWren !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_e1: got tick %b wren %b want 1/0", frameTick, ramWren); end
    nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd3 || ramData !== 8'h11) begin mismatched++; $display("[TB] FAIL drain_first: got %b %0d/%h want 1 3/11", ramWren, ramAddr, ramData); end
    compared++; if (frameTick !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_tick_width: got %b want 0", frameTick); end
    nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd4 || ramData !== 8'h22) begin mismatched++; $display("[TB] FAIL drain_second: got %b %0d/%h want 1 4/22", ramWren, ramAddr, ramData); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_busy_done: got %b want 0", busy); end
    nextCycle();
    compared++; if (ramWren !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_stop: got %b want 0", ramWren); end
    repeat (6) nextCycle();
    y = 9'd0;
    repeat (4) nextCycle();
    compared++; if (tickCount != 1) begin mismatched++; $display("[TB] FAIL drain_tick_count: got %0d want 1", tickCount); end
    compared++; if (wrQ.size() != 2) begin mismatched++; $display("[TB] FAIL drain_write_count: got %0d want 2", wrQ.size()); end
  endtask

  task automatic test_arbitration();
    int n0, n1;
    logic expR0, expR1;
    n0 = 0; n1 = 0;
    expQ.delete();
    rst = 1'b1; y = 9'd100;
    nextCycle(); nextCycle();
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; a0 = 5'd2; a1 = 5'd9;
    for (int i = 0; i < 10; i++) begin
      d0 = 8'(8'hA0 + n0);
      d1 = 8'(8'hB0 + n1);
      #1;
      expR0 = (i < 8) && (i % 2 == 0);
      expR1 = (i < 8) && (i % 2 == 1);
      compared++; if (r0 !== expR0 || r1 !== expR1) begin mismatched++; $display("[TB] FAIL arb_grant_%0d: got %b%b want %b%b", i, r0, r1, expR0, expR1); end
      if (expR0) begin expQ.push_back({a0, d0}); n0++; end
      if (expR1) begin expQ.push_back({a1, d1}); n1++; end
      nextCycle();
    end
    v0 = 1'b0; v1 = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL arb_busy_full: got %b want 1", busy); end
    wrQ.delete();
    y = 9'd272;
    repeat (14) nextCycle();
    y = 9'd0;
    nextCycle();
    compared++; if (wrQ.size() != 8) begin mismatched++; $display("[TB] FAIL arb_write_count: got %0d want 8", wrQ.size()); end
    for (int k = 0; k < 8 && k < wrQ.size(); k++) begin
      compared++; if (wrQ[k] !== expQ[k]) begin mismatched++; $display("[TB] FAIL arb_order_%0d: got %h want %h", k, wrQ[k], expQ[k]); end
    end
  endtask

  task automatic test_clear();
    logic [12:0] expEntry;
    wrQ.delete();
    y = 9'd50;
    clr = 1'b1;
    v0 = 1'b1; a0 = 5'd5; d0 = 8'hAA;
    nextCycle();
    clr = 1'b0; v0 = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_busy_pending: got %b want 1", busy); end
    y = 9'd272;
    repeat (33) nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd31 || ramData !== 8'h00 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_last_step: got %b %0d/%h busy %b want 1 31/00 busy 1", ramWren, ramAddr, ramData, busy); end
    nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd5 || ramData !== 8'hAA) begin mismatched++; $display("[TB] FAIL clear_then_queued: got %b %0d/%h want 1 5/AA", ramWren, ramAddr, ramData); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_busy_fall: got %b want 0", busy); end
    repeat (10) nextCycle();
    y = 9'd0;
    nextCycle();
    compared++; if (wrQ.size() != 33) begin mismatched++; $display("[TB] FAIL clear_write_count: got %0d want 33", wrQ.size()); end
    for (int k = 0; k < 33 && k < wrQ.size(); k++) begin
      expEntry = (k == 32) ? {5'd5, 8'hAA} : {5'(k), 8'h00};
      compared++; if (wrQ[k] !== expEntry) begin mismatched++; $display("[TB] FAIL clear_write_%0d: got %h want %h", k, wrQ[k], expEntry); end
    end
  endtask

  task automatic test_clear_resume();
    logic [12:0] expEntry;
    wrQ.delete();
    y = 9'd50;
    clr = 1'b1;
    nextCycle();
    clr = 1'b0;
    y = 9'd272;
    repeat (11) nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd9) begin mismatched++; $display("[TB] FAIL resume_tenth: got %b %0d want 1 9", ramWren, ramAddr); end
    y = 9'd0;
    nextCycle();
    compared++; if (ramWren !== 1'b0) begin mismatched++; $display("[TB] FAIL resume_pause: got %b want 0", ramWren); end
    repeat (5) nextCycle();
    compared++; if (wrQ.size() != 10 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL resume_paused_state: got writes %0d busy %b want 10 1", wrQ.size(), busy); end
    y = 9'd272;
    nextCycle();
    compared++; if (ramWren !== 1'b1 || ramAddr !== 5'd10) begin mismatched++; $display("[TB] FAIL resume_restart: got %b %0d want 1 10", ramWren, ramAddr); end
    repeat (30) nextCycle();
    y = 9'd0;
    nextCycle();
    compared++; if (wrQ.size() != 32) begin mismatched++; $display("[TB] FAIL resume_write_count: got %0d want 32", wrQ.size()); end
    for (int k = 0; k < 32 && k < wrQ.size(); k++) begin
      expEntry = {5'(k), 8'h00};
      compared++; if (wrQ[k] !== expEntry) begin mismatched++; $display("[TB] FAIL resume_write_%0d: got %h want %h", k, wrQ[k], expEntry); end
    end
  endtask

  task automatic test_full_drain();
    logic [12:0] expEntry;
    wrQ.delete();
    y = 9'd100;
    for (int k = 0; k < 8; k++) begin
      v0 = 1'b1; a0 = 5'(k + 10); d0 = 8'(8'hC0 + k);
      #1;
      compared++; if (r0 !== 1'b1) begin mismatched++; $display("[TB] FAIL full_fill_%0d: ready0 got %b want 1", k, r0); end
      nextCycle();
    end
    v0 = 1'b0;
    v1 = 1'b1; a1 = 5'd7; d1 = 8'h77;
    #1;
    compared++; if (r1 !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready1_full: got %b want 0", r1); end
    y = 9'd272;
    nextCycle();
    compared++; if (r1 !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready1_before_pop: got %b want 0", r1); end
    nextCycle();
    compared++; if (r1 !== 1'b1) begin mismatched++; $display("[TB] FAIL full_ready1_after_pop: got %b want 1", r1); end
    nextCycle();
    v1 = 1'b0;
    repeat (15) nextCycle();
    y = 9'd0;
    nextCycle();
    compared++; if (wrQ.size() != 9) begin mismatched++; $display("[TB] FAIL full_write_count: got %0d want 9", wrQ.size()); end
    for (int k = 0; k < 9 && k < wrQ.size(); k++) begin
      expEntry = (k == 8) ? {5'd7, 8'h77} : {5'(k + 10), 8'(8'hC0 + k)};
      compared++; if (wrQ[k] !== expEntry) begin mismatched++; $display("[TB] FAIL full_write_%0d: got %h want %h", k, wrQ[k], expEntry); end
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting tilemap_write_scheduler bench");
    test_reset();
    test_reset_mid_drain();
    test_basic_drain();
    test_arbitration();
    test_clear();
    test_clear_resume();
    test_full_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
